// File: rtl/ad_ip_jesd204_tpl_adc_deframer.sv
// JESD204 transport-layer ADC deframer: lane octets -> per-channel 16-bit samples, N-bit formatting, per-channel PN9 monitor.
// Latency: adc_valid/adc_data two link_clk cycles after an accepted link_valid beat; pn_oos/pn_err update on the same edge as adc_valid.
// Backpressure: none; link_ready is constant 1 out of reset, and every link_valid beat is accepted.
// Ports: link_clk/link_rst (async active-high), link_valid/link_ready/link_data in, adc_dfmt_enable/pn_clear control,
//        adc_valid/adc_data out, pn_oos/pn_err per-channel PN9 status.
module ad_ip_jesd204_tpl_adc_deframer #(
    parameter int NUM_LANES            = 4,
    parameter int NUM_CHANNELS         = 2,
    parameter int OCTETS_PER_BEAT      = 4,
    parameter int CONVERTER_RESOLUTION = 14,
    localparam int DPW    = OCTETS_PER_BEAT * 8 * NUM_LANES / NUM_CHANNELS / 16,
    localparam int DATA_W = NUM_LANES * 8 * OCTETS_PER_BEAT
) (
    input  logic                             link_clk,
    input  logic                             link_rst,
    input  logic                             link_valid,
    output logic                             link_ready,
    input  logic [DATA_W-1:0]                link_data,
    input  logic [NUM_CHANNELS-1:0]          adc_dfmt_enable,
    input  logic                             pn_clear,
    output logic [NUM_CHANNELS-1:0]          adc_valid,
    output logic [NUM_CHANNELS*16*DPW-1:0]   adc_data,
    output logic [NUM_CHANNELS-1:0]          pn_oos,
    output logic [NUM_CHANNELS-1:0]          pn_err
);

    localparam int WPL     = OCTETS_PER_BEAT / 2;       // 16-bit words per lane
    localparam int WORDS   = NUM_LANES * WPL;
    localparam int CH_BITS = DPW * 16;
    localparam int SHIFT   = 16 - CONVERTER_RESOLUTION;

    localparam logic [4:0] LOCK_LAST = 5'd15;           // 16th consecutive match locks
    localparam logic [2:0] LOSS_LAST = 3'd3;            // 4th consecutive miss drops sync

    typedef enum logic {PN_OOS = 1'b0, PN_SYNC = 1'b1} pn_state_t;

    logic [WORDS-1:0][15:0] deframed;
    logic [WORDS-1:0][15:0] s1_words;
    logic [WORDS-1:0][15:0] formatted;
    logic                   s1_vld;

    // Extends a PN9 (x^9+x^5+1) sequence: bit n = bit n-5 ^ bit n-9.
    // Higher index is older; seed[8] is the oldest of the last nine bits seen.
    function automatic logic [CH_BITS-1:0] pn9_predict(input logic [8:0] seed);
        logic [CH_BITS+8:0] ext;
        ext = '0;
        ext[CH_BITS+8 -: 9] = seed;
        for (int p = CH_BITS - 1; p >= 0; p--) begin
            ext[p] = ext[p+9] ^ ext[p+5];
        end
        return ext[CH_BITS-1:0];
    endfunction

    // Octet 2k of a lane is first on the wire and becomes the word MSB.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        for (genvar k = 0; k < WPL; k++) begin : g_word
            assign deframed[l*WPL+k] = {link_data[l*8*OCTETS_PER_BEAT + 16*k     +: 8],
                                        link_data[l*8*OCTETS_PER_BEAT + 16*k + 8 +: 8]};
        end
    end

    always_ff @(posedge link_clk or posedge link_rst) begin
        if (link_rst) begin
            s1_vld   <= 1'b0;
            s1_words <= '0;
        end else begin
            s1_vld <= link_valid;
            if (link_valid) begin
                s1_words <= deframed;
            end
        end
    end

    // Flipping bit 15 inverts bit N-1 of the upper N bits; the arithmetic
    // shift then drops the control bits and sign-extends in one step.
    for (genvar n = 0; n < WORDS; n++) begin : g_fmt
        logic signed [15:0] flipped;
        assign flipped      = {s1_words[n][15] ^ adc_dfmt_enable[n/DPW], s1_words[n][14:0]};
        assign formatted[n] = flipped >>> SHIFT;
    end

    always_ff @(posedge link_clk or posedge link_rst) begin
        if (link_rst) begin
            link_ready <= 1'b0;
            adc_valid  <= '0;
            adc_data   <= '0;
        end else begin
            link_ready <= 1'b1;
            adc_valid  <= {NUM_CHANNELS{s1_vld}};
            if (s1_vld) begin
                adc_data <= formatted;
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pn
        logic [CH_BITS-1:0] bits;
        logic [CH_BITS-1:0] expect_bits;
        logic               is_match;
        pn_state_t          state;
        pn_state_t          state_nxt;
        logic [8:0]         seed;
        logic               seeded;
        logic [4:0]         match_cnt;
        logic [4:0]         match_nxt;
        logic [2:0]         miss_cnt;
        logic [2:0]         miss_nxt;
        logic               err_set;
        logic               err_q;

        // Sample 0 (oldest) occupies the MSBs so the vector reads as the serial stream.
        for (genvar i = 0; i < DPW; i++) begin : g_bits
            assign bits[(DPW-1-i)*16 +: 16] = s1_words[c*DPW+i];
        end

        assign expect_bits = pn9_predict(seed);
        assign is_match    = (bits == expect_bits);

        // Counters never pass their terminal values: reaching them changes
        // state and clears the counter, so they cannot wrap.
        always_comb begin
            state_nxt = state;
            match_nxt = match_cnt;
            miss_nxt  = miss_cnt;
            err_set   = 1'b0;
            if (s1_vld && seeded) begin
                case (state)
                    PN_OOS: begin
                        if (!is_match) begin
                            match_nxt = '0;
                        end else if (match_cnt >= LOCK_LAST) begin
                            state_nxt = PN_SYNC;
                            match_nxt = '0;
                            miss_nxt  = '0;
                        end else begin
                            match_nxt = match_cnt + 5'd1;
                        end
                    end
                    PN_SYNC: begin
                        if (is_match) begin
                            miss_nxt = '0;
                        end else begin
                            err_set = 1'b1;
                            if (miss_cnt >= LOSS_LAST) begin
                                state_nxt = PN_OOS;
                                miss_nxt  = '0;
                                match_nxt = '0;
                            end else begin
                                miss_nxt = miss_cnt + 3'd1;
                            end
                        end
                    end
                    default: state_nxt = PN_OOS;
                endcase
            end
        end

        always_ff @(posedge link_clk or posedge link_rst) begin
            if (link_rst) begin
                state     <= PN_OOS;
                match_cnt <= '0;
                miss_cnt  <= '0;
                seed      <= '0;
                seeded    <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                state     <= state_nxt;
                match_cnt <= match_nxt;
                miss_cnt  <= miss_nxt;
                if (s1_vld) begin
                    seed   <= bits[8:0];
                    seeded <= 1'b1;
                end
                // A mismatch on the same edge as pn_clear keeps the error set.
                if (err_set) begin
                    err_q <= 1'b1;
                end else if (pn_clear) begin
                    err_q <= 1'b0;
                end
            end
        end

        assign pn_oos[c] = (state == PN_OOS);
        assign pn_err[c] = err_q;
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv
// Randomized scoreboard bench for ad_ip_jesd204_tpl_adc_deframer with a serial-bitstream reference model.
// Covers deframe mapping, formatting, valid gaps, PN9 lock/error/loss, pn_clear and mid-stream reset.
module tb_ad_ip_jesd204_tpl_adc_deframer;

    localparam int NL  = 4;
    localparam int NC  = 2;
    localparam int OPB = 4;
    localparam int N   = 14;
    localparam int DPW = OPB * 8 * NL / NC / 16;
    localparam int DW  = NL * 8 * OPB;

    typedef struct {
        logic [DW-1:0] dat;
        logic [NC-1:0] oos;
        logic [NC-1:0] err;
        int            cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 link_rst;
    logic                 link_valid;
    logic                 link_ready;
    logic [DW-1:0]        link_data;
    logic [NC-1:0]        adc_dfmt_enable;
    logic                 pn_clear;
    logic [NC-1:0]        adc_valid;
    logic [NC*16*DPW-1:0] adc_data;
    logic [NC-1:0]        pn_oos;
    logic [NC-1:0]        pn_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t q[$];

    // reference model state: last nine bits per channel, newest in bit 0
    logic [8:0] m_last   [NC];
    bit         m_seeded [NC];
    bit         m_sync   [NC];
    bit         m_err    [NC];
    int         m_good   [NC];
    int         m_bad    [NC];
    logic [8:0] gen = 9'h1FF;

    ad_ip_jesd204_tpl_adc_deframer #(
        .NUM_LANES(NL), .NUM_CHANNELS(NC), .OCTETS_PER_BEAT(OPB), .CONVERTER_RESOLUTION(N)
    ) dut (
        .link_clk(clk), .link_rst(link_rst), .link_valid(link_valid), .link_ready(link_ready),
        .link_data(link_data), .adc_dfmt_enable(adc_dfmt_enable), .pn_clear(pn_clear),
        .adc_valid(adc_valid), .adc_data(adc_data), .pn_oos(pn_oos), .pn_err(pn_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [15:0] get_word(input logic [DW-1:0] d, input int n);
        int base;
        base = (n / (OPB/2)) * OPB * 8 + (n % (OPB/2)) * 16;
        return {d[base +: 8], d[base+8 +: 8]};
    endfunction

    function automatic logic [DW-1:0] set_word(input logic [DW-1:0] d, input int n, input logic [15:0] w);
        int base;
        logic [DW-1:0] r;
        r = d;
        base = (n / (OPB/2)) * OPB * 8 + (n % (OPB/2)) * 16;
        r[base +: 8]   = w[15:8];
        r[base+8 +: 8] = w[7:0];
        return r;
    endfunction

    // upper N bits as an unsigned number, optional MSB flip, then two's-complement value
    function automatic logic [15:0] fmt(input logic [15:0] w, input bit df);
        int v;
        v = int'(w) >> (16 - N);
        if (df) v = v ^ (1 << (N-1));
        if (v >= (1 << (N-1))) v = v - (1 << N);
        return 16'(v);
    endfunction

    task automatic next_pn_word(output logic [15:0] w);
        logic b;
        w = '0;
        for (int j = 0; j < 16; j++) begin
            b   = gen[4] ^ gen[8];
            gen = {gen[7:0], b};
            w   = {w[14:0], b};
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_last[c] = '0; m_seeded[c] = 0; m_sync[c] = 0;
            m_err[c] = 0; m_good[c] = 0; m_bad[c] = 0;
        end
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input int t);
        exp_t       e;
        logic [15:0] w;
        bit          ok;
        logic        x;
        e.dat = '0;
        for (int c = 0; c < NC; c++) begin
            ok = 1;
            for (int i = 0; i < DPW; i++) begin
                w = get_word(d, c*DPW + i);
                e.dat[(c*DPW+i)*16 +: 16] = fmt(w, adc_dfmt_enable[c]);
                for (int b = 15; b >= 0; b--) begin
                    x = w[b];
                    if (x != (m_last[c][4] ^ m_last[c][8])) ok = 0;
                    m_last[c] = {m_last[c][7:0], x};
                end
            end
            if (m_seeded[c]) begin
                if (!m_sync[c]) begin
                    if (ok) begin
                        m_good[c]++;
                        if (m_good[c] == 16) begin m_sync[c] = 1; m_bad[c] = 0; end
                    end else m_good[c] = 0;
                end else begin
                    if (ok) m_bad[c] = 0;
                    else begin
                        m_err[c] = 1;
                        m_bad[c]++;
                        if (m_bad[c] == 4) begin m_sync[c] = 0; m_good[c] = 0; end
                    end
                end
            end
            m_seeded[c] = 1;
            e.oos[c] = !m_sync[c];
            e.err[c] = m_err[c];
        end
        e.cyc = t + 2;
        q.push_back(e);
    endtask

    // called at a negedge, returns at the next negedge
    task automatic drive(input logic [DW-1:0] d, input bit v);
        link_data  = d;
        link_valid = v;
        if (v) model_beat(d, cyc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(rand_data(), 0);
    endtask

    task automatic pn_beat(input bit flip, output logic [DW-1:0] d);
        logic [15:0] w;
        d = rand_data();
        for (int i = 0; i < DPW; i++) begin
            next_pn_word(w);
            if (flip && i == 0) w[15] = ~w[15];
            d = set_word(d, i, w);
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // scoreboard monitor
    logic [DW-1:0] last_dat = '0;
    always @(negedge clk) begin
        exp_t e;
        if (link_rst) begin
            last_dat = '0;
        end else if (adc_valid != '0) begin
            check("valid_all_channels", 128'(adc_valid), 128'({NC{1'b1}}));
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got adc_valid=%b want no output", adc_valid);
            end else begin
                e = q.pop_front();
                check("latency_cycle", 128'(cyc), 128'(e.cyc));
                check("adc_data", 128'(adc_data), 128'(e.dat));
                check("pn_oos", 128'(pn_oos), 128'(e.oos));
                check("pn_err", 128'(pn_err), 128'(e.err));
            end
            last_dat = adc_data;
        end else begin
            check("data_hold", 128'(adc_data), 128'(last_dat));
        end
    end

    initial begin
        logic [DW-1:0] d;
        link_rst = 1; link_valid = 0; link_data = '0; adc_dfmt_enable = '0; pn_clear = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(link_ready), 128'(0));
        check("rst_valid", 128'(adc_valid), 128'(0));
        check("rst_data", 128'(adc_data), 128'(0));
        check("rst_oos", 128'(pn_oos), 128'({NC{1'b1}}));
        check("rst_err", 128'(pn_err), 128'(0));
        link_rst = 0;
        @(negedge clk);
        check("ready_after_rst", 128'(link_ready), 128'(1));

        // deframe mapping: lane0 octets 12,34,56,78
        d = rand_data(); d[31:0] = 32'h7856_3412;
        drive(d, 1);
        idle(1);
        check("map_s0", 128'(adc_data[15:0]), 128'(16'h048D));
        check("map_s1", 128'(adc_data[31:16]), 128'(16'h159E));
        idle(2);

        // formatting of 0x8004 with and without offset-binary conversion
        adc_dfmt_enable = 2'b01;
        d = rand_data(); d[15:0] = 16'h0480;
        drive(d, 1);
        idle(1);
        check("fmt_dfmt1", 128'(adc_data[15:0]), 128'(16'h0001));
        idle(2);
        adc_dfmt_enable = 2'b00;
        drive(d, 1);
        idle(1);
        check("fmt_dfmt0", 128'(adc_data[15:0]), 128'(16'hE001));
        idle(2);

        // valid gap pattern then random traffic
        drive(rand_data(), 1); drive(rand_data(), 0);
        drive(rand_data(), 1); drive(rand_data(), 1);
        idle(3);
        for (int b = 0; b < 4; b++) begin
            adc_dfmt_enable = NC'($urandom);
            for (int i = 0; i < 15; i++) drive(rand_data(), ($urandom_range(0, 3) != 0));
            idle(3);
        end

        // PN lock: fresh reset, then continuous PN9 on channel 0
        link_rst = 1; model_reset(); q.delete(); @(negedge clk); link_rst = 0; @(negedge clk);
        for (int i = 0; i < 16; i++) begin pn_beat(0, d); drive(d, 1); end
        idle(1);
        check("oos_before_lock", 128'(pn_oos[0]), 128'(1));
        pn_beat(0, d); drive(d, 1);
        idle(2);
        check("locked", 128'(pn_oos), 128'(2'b10));
        check("no_err_locked", 128'(pn_err), 128'(0));
        for (int i = 0; i < 6; i++) begin pn_beat(0, d); drive(d, ($urandom_range(0, 2) != 0)); end

        // single bit flip in sync
        pn_beat(1, d); drive(d, 1);
        for (int i = 0; i < 3; i++) begin pn_beat(0, d); drive(d, 1); end
        idle(3);
        check("err_set", 128'(pn_err), 128'(2'b01));
        check("still_sync", 128'(pn_oos[0]), 128'(0));
        pn_clear = 1; @(negedge clk); pn_clear = 0;
        for (int c = 0; c < NC; c++) m_err[c] = 0;
        check("err_cleared", 128'(pn_err), 128'(0));

        // four bad beats drop sync, then relock
        for (int i = 0; i < 4; i++) drive(rand_data(), 1);
        idle(3);
        check("lost_sync", 128'(pn_oos[0]), 128'(1));
        for (int i = 0; i < 24; i++) begin pn_beat(0, d); drive(d, ($urandom_range(0, 4) != 0)); end

        // reset mid-stream
        link_rst = 1;
        #1;
        check("mid_rst_valid", 128'(adc_valid), 128'(0));
        check("mid_rst_data", 128'(adc_data), 128'(0));
        check("mid_rst_oos", 128'(pn_oos), 128'({NC{1'b1}}));
        check("mid_rst_err", 128'(pn_err), 128'(0));
        check("mid_rst_ready", 128'(link_ready), 128'(0));
        q.delete(); model_reset();
        link_valid = 1; link_data = rand_data();
        @(negedge clk);
        link_rst = 0;
        idle(4);
        for (int i = 0; i < 6; i++) begin pn_beat(0, d); drive(d, 1); end
        idle(5);
        check("scoreboard_empty", 128'(q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
